// File: rtl/barrido_tabla_inciso2.sv
`default_nettype none
// ============================================================================
//  Module      : barrido_tabla_inciso2
//  Description : Truth-table sweeper/checker for a 5-input function under test.
//                Drives all 32 vectors on {X,Y,Z,K,M}, waits SETTLE cycles,
//                samples F_in, builds a 32-bit signature and counts
//                mismatches against EXP_MASK outside the DC_MASK positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrido_tabla_inciso2 #(
    parameter logic [31:0] EXP_MASK = 32'h0A26_8C5C,
    parameter logic [31:0] DC_MASK  = 32'h0198_0321,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        K,
    output logic        M,
    input  logic        F_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] sig,
    output logic [5:0]  err_count,
    output logic        err_valid,
    output logic [4:0]  first_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] C_SETTLE  = 4'(SETTLE);
    localparam logic [4:0] C_LAST_IX = 5'd31;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [31:0] sig_q;
    logic [5:0]  err_count_q;
    logic        err_valid_q;
    logic [4:0]  first_err_q;

    // Sample at the current vector disagrees with the expected table at a
    // position that is not a don't-care.
    logic w_mismatch;
    assign w_mismatch = !DC_MASK[idx_q] && (F_in != EXP_MASK[idx_q]);

    // Sweep controller: vector stepping, settle counting, signature capture
    // and error bookkeeping, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sig_q       <= 32'd0;
            err_count_q <= 6'd0;
            err_valid_q <= 1'b0;
            first_err_q <= 5'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start together with abort is treated as no request
                    if (start && !abort) begin
                        state_q     <= ST_RUN;
                        idx_q       <= 5'd0;
                        cnt_q       <= C_SETTLE;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        sig_q       <= 32'd0;
                        err_count_q <= 6'd0;
                        err_valid_q <= 1'b0;
                        first_err_q <= 5'd0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // partial signature and error state are left visible
                        state_q <= ST_IDLE;
                        idx_q   <= 5'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        sig_q[idx_q] <= F_in;
                        if (w_mismatch) begin
                            err_count_q <= err_count_q + 6'd1;
                            err_valid_q <= 1'b1;
                            if (!err_valid_q) begin
                                first_err_q <= idx_q;
                            end
                        end
                        if (idx_q == C_LAST_IX) begin
                            state_q <= ST_IDLE;
                            idx_q   <= 5'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // final count includes the sample taken right now
                            pass_q  <= (err_count_q == 6'd0) && !w_mismatch;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                            cnt_q <= C_SETTLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign {X, Y, Z, K, M} = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign sig             = sig_q;
    assign err_count       = err_count_q;
    assign err_valid       = err_valid_q;
    assign first_err       = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_barrido_tabla_inciso2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrido_tabla_inciso2
//  Description : Scoreboard bench for barrido_tabla_inciso2. The function under
//                test is a 32-entry lookup table; expected sweep results come
//                from a table-level model (signature = table, errors = popcount
//                of disagreements outside don't-cares).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrido_tabla_inciso2;

    localparam logic [31:0] C_EXP = 32'h0A26_8C5C;
    localparam logic [31:0] C_DC  = 32'h0198_0321;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    wire         X, Y, Z, K, M;
    wire         F_in;
    wire         busy, done, pass;
    wire  [31:0] sig;
    wire  [5:0]  err_count;
    wire         err_valid;
    wire  [4:0]  first_err;
    logic [31:0] tbl;
    wire  [4:0]  vec = {X, Y, Z, K, M};
    assign F_in = tbl[vec];

    // second instance with SETTLE=0
    logic        start0;
    wire         X0, Y0, Z0, K0, M0;
    wire         F_in0;
    wire         busy0, done0, pass0;
    wire  [31:0] sig0;
    wire  [5:0]  err_count0;
    wire         err_valid0;
    wire  [4:0]  first_err0;
    logic [31:0] tbl0;
    wire  [4:0]  vec0 = {X0, Y0, Z0, K0, M0};
    assign F_in0 = tbl0[vec0];

    barrido_tabla_inciso2 #(.EXP_MASK(C_EXP), .DC_MASK(C_DC), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .X(X), .Y(Y), .Z(Z), .K(K), .M(M), .F_in(F_in),
        .busy(busy), .done(done), .pass(pass), .sig(sig),
        .err_count(err_count), .err_valid(err_valid), .first_err(first_err)
    );

    barrido_tabla_inciso2 #(.EXP_MASK(C_EXP), .DC_MASK(C_DC), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(1'b0),
        .X(X0), .Y(Y0), .Z(Z0), .K(K0), .M(M0), .F_in(F_in0),
        .busy(busy0), .done(done0), .pass(pass0), .sig(sig0),
        .err_count(err_count0), .err_valid(err_valid0), .first_err(first_err0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    typedef struct {
        logic [31:0] sig;
        int          errs;
        logic        ev;
        int          fe;
        logic        pass;
        int          dcyc;
    } exp_t;

    exp_t sbq[$];

    // Table-level reference: a full sweep captures the table itself.
    function automatic exp_t model(input logic [31:0] t, input int e0, input int settle);
        exp_t        m;
        logic [31:0] bad;
        bad    = (t ^ C_EXP) & ~C_DC;
        m.sig  = t;
        m.errs = $countones(bad);
        m.ev   = (m.errs != 0);
        m.fe   = 0;
        for (int i = 31; i >= 0; i--) if (bad[i]) m.fe = i;
        m.pass = (m.errs == 0);
        m.dcyc = e0 + 32 * (settle + 1);
        return m;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding sweep.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.dcyc);
                chk("sig", sig, e.sig);
                chk("err_count", {26'd0, err_count}, e.errs);
                chk("err_valid", {31'd0, err_valid}, {31'd0, e.ev});
                if (e.ev) chk("first_err", {27'd0, first_err}, e.fe);
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Issue a sweep at the current negedge; returns at the negedge where done
    // is high, so a following call exercises start in the done cycle.
    task automatic run_sweep(input logic [31:0] t, input bit mid_start);
        bit seen;
        tbl   = t;
        start = 1'b1;
        sbq.push_back(model(t, cyc + 1, 1));
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            start = (mid_start && i == 20);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_vec(input logic [4:0] v);
        for (int i = 0; i < 200 && vec != v; i++) @(negedge clk);
        chk("reach_vec", {27'd0, vec}, {27'd0, v});
    endtask

    initial begin
        logic [31:0] t;
        int          e0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0;
        tbl = C_EXP; tbl0 = 32'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_vec", {27'd0, vec}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_sig", sig, 32'd0);
        chk("rst_err_count", {26'd0, err_count}, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_first_err", {27'd0, first_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed tables, chained back-to-back
        run_sweep(C_EXP, 1'b0);
        run_sweep(32'h0AAE_8D5D, 1'b0);
        run_sweep(32'h0000_0000, 1'b1);
        run_sweep(32'hFFFF_FFFF, 1'b0);

        // results hold after done; start+abort together in IDLE does nothing
        repeat (3) @(negedge clk);
        chk("pass_held", {31'd0, pass}, 32'd0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", {31'd0, busy}, 32'd0);
        chk("sa_err_count", {26'd0, err_count}, 32'd12);
        chk("sa_first_err", {27'd0, first_err}, 32'd1);
        chk("sa_sig", sig, 32'hFFFF_FFFF);

        // random tables: fully random and single-bit corruptions of EXP
        for (int r = 0; r < 6; r++) begin
            if (r[0]) t = $urandom;
            else      t = C_EXP ^ (32'd1 << $urandom_range(31, 0));
            run_sweep(t, 1'b0);
        end
        @(negedge clk);

        // abort at idx 10: partial signature covers vectors 0..9 only
        t     = $urandom;
        tbl   = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(5'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_vec", {27'd0, vec}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        chk("abort_sig", sig, t & 32'h0000_03FF);
        chk("abort_err_count", {26'd0, err_count},
            $countones((t ^ C_EXP) & ~C_DC & 32'h0000_03FF));
        repeat (80) @(negedge clk);
        chk("abort_still_idle", {31'd0, busy}, 32'd0);

        // rst at idx 20: everything back to reset values
        tbl   = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(5'd20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_vec", {27'd0, vec}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_sig", sig, 32'd0);
        chk("mrst_err_count", {26'd0, err_count}, 32'd0);
        chk("mrst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("mrst_first_err", {27'd0, first_err}, 32'd0);
        repeat (70) @(negedge clk);
        chk("mrst_no_resume", {31'd0, busy}, 32'd0);

        // SETTLE=0: vector steps every cycle, done 32 cycles after start
        tbl0   = C_EXP ^ 32'h0000_0004;
        start0 = 1'b1;
        e0     = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("s0_vec", {27'd0, vec0}, k);
            @(negedge clk);
        end
        chk("s0_done_cycle", cyc, e0 + 32);
        chk("s0_done", {31'd0, done0}, 32'd1);
        chk("s0_sig", sig0, C_EXP ^ 32'h0000_0004);
        chk("s0_err_count", {26'd0, err_count0}, 32'd1);
        chk("s0_first_err", {27'd0, first_err0}, 32'd2);
        chk("s0_pass", {31'd0, pass0}, 32'd0);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/barrido_tabla_inciso2.md
# barrido_tabla_inciso2

Sequential truth-table sweeper and checker for the 5-input minterm functions of inciso 2. It drives all 32 input combinations onto X, Y, Z, K, M of a combinational function block and samples the block's single-bit output after a settle delay. It builds a 32-bit output signature and compares it against an expected minterm mask, ignoring don't-care positions. It sits on the input side of the function under test and reads back its output.

## Interface
Parameters:
- EXP_MASK, 32'h0A26_8C5C, expected output per index; bit i = required F for vector i (minterms 2,3,4,6,10,11,15,17,18,21,25,27).
- DC_MASK, 32'h0198_0321, don't-care positions (0,5,8,9,19,20,23,24); never counted as errors.
- SETTLE, 1, number of idle cycles between applying a vector and sampling it; legal range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a running sweep.
- X, Y, Z, K, M  output  1 each  registered drive vector; index = {X,Y,Z,K,M}, X is the MSB.
- F_in  input  1  output of the function under test.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a full sweep completes.
- pass  output  1  last completed sweep had zero errors; held until the next start.
- sig  output  32  captured F_in per index.
- err_count  output  6  number of non-DC mismatches, 0..32.
- err_valid  output  1  at least one mismatch recorded.
- first_err  output  5  index of the first mismatch; meaningful only when err_valid=1.

## Operation
- States: IDLE and RUN. Internal registers: 5-bit idx and 4-bit cnt.
- IDLE, start=1 and abort=0 at edge E0:
  - go to RUN, idx=0, cnt=SETTLE, busy=1.
  - clear sig, err_count, err_valid, first_err and pass.
- RUN, at each edge:
  - if abort=1: go to IDLE, idx=0, busy=0, no done pulse, pass=0; sig and error registers keep their partial contents.
  - else if cnt>0: cnt decrements.
  - else (cnt=0), sample F_in:
    - sig[idx]=F_in.
    - Mismatch when DC_MASK[idx]=0 and F_in≠EXP_MASK[idx]. On a mismatch, err_count increments; on the first mismatch, first_err=idx and err_valid=1.
    - If idx=31: go to IDLE, done=1 for one cycle, busy=0, idx=0, pass=1 only if the final err_count (including this sample) is 0.
    - Otherwise idx increments and cnt reloads to SETTLE.
- start while in RUN is ignored.
- start and abort both high in IDLE: stays in IDLE, nothing is cleared.
- The X..M outputs always equal idx.

## Timing
- Reset values: X=Y=Z=K=M=0, busy=0, done=0, pass=0, sig=0, err_count=0, err_valid=0, first_err=0, state IDLE, cnt=0.
- rst during RUN: all registers return to their reset values at that edge, and done is not pulsed.
- Vector i is driven starting at edge E0+i·(SETTLE+1).
- Vector i is sampled at edge E0+(i+1)·(SETTLE+1) using the F_in value present just before that edge. The function under test must therefore settle within SETTLE+1 clock periods.
- done is high in the cycle after edge E0+32·(SETTLE+1):
  - SETTLE=1: 64 cycles after E0.
  - SETTLE=0: 32 cycles after E0.
- sig, err_count and pass are stable in the same cycle done is high.
- A new start is accepted in the cycle done is high, since the state is already IDLE.
- err_count needs no saturation: 32 fits in 6 bits.

## Test plan
- Correct S_OR4-type model on F_in, SETTLE=1: start → done 64 cycles later; sig=32'h0A26_8C5C, pass=1, err_count=0, err_valid=0.
- S_OR5-type model (ones added at don't-cares 0, 8, 19, 23): sig=32'h0AAE_8D5D, pass=1, err_count=0.
- F_in stuck at 0: err_count=12, first_err=2, err_valid=1, pass=0.
- F_in stuck at 1: err_count=12, first_err=1, pass=0, sig=32'hFFFF_FFFF.
- SETTLE=0: done 32 cycles after start, and the drive vector steps every cycle 0→31.
- Control boundaries:
  - abort at idx=10 → busy=0 next cycle, no done, X..M=0.
  - start pulsed mid-run → ignored, done still at the original cycle.
  - rst at idx=20 → every output at its reset value after that edge.
